// File: rtl/job_pkg.sv
// Shared types and widths for the job front-end of the nonce-search core.
package job_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } job_state_t;

  localparam int JOB_BYTES = 13;
  localparam int PAYLOAD_W = 96;
  localparam int TARGET_W  = 8;
  localparam int NONCE_W   = 32;
  localparam int HASH_W    = 24;
  localparam int ASM_W     = PAYLOAD_W + TARGET_W;
  localparam int CNT_W     = $clog2(JOB_BYTES);

endpackage

// File: rtl/job_byte_assembler.sv
// Collects the 13-byte job stream MSB-first; o_job is the full job including the byte on the wire,
// so the caller can latch it on the same edge that o_last_byte is high. No internal backpressure.
module job_byte_assembler
  import job_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_byte_vld,
  input  logic [7:0]       i_byte,
  output logic [ASM_W-1:0] o_job,
  output logic             o_last_byte
);

  // Only the 12 earlier bytes need storage; the 13th is taken straight from the input.
  logic [ASM_W-9:0] r_asm;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last      = i_byte_vld && (r_cnt == CNT_W'(JOB_BYTES - 1));
  assign o_job       = {r_asm, i_byte};
  assign o_last_byte = w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (i_byte_vld) begin
      r_asm <= {r_asm[ASM_W-17:0], i_byte};
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/job_loader.sv
// Job front-end: load 13 bytes, one inactive ARM cycle, RUN with watchdog, hold result until res_ready.
// Last byte to active=1 is 2 edges, terminado to res_valid is 1 edge; in_ready only while loading.
module job_loader
  import job_pkg::*;
#(
  parameter logic [31:0] MAX_CYCLES = 32'd1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [TARGET_W-1:0]  target,
  output logic                 active,
  input  logic                 terminado,
  input  logic [NONCE_W-1:0]   nonce_in,
  input  logic [HASH_W-1:0]    hash_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NONCE_W-1:0]   res_nonce,
  output logic [HASH_W-1:0]    res_hash,
  output logic                 res_timeout,
  output logic                 busy
);

  job_state_t           r_state;
  logic [31:0]          r_wdog;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [TARGET_W-1:0]  r_target;
  logic                 r_active;
  logic                 r_res_valid;
  logic [NONCE_W-1:0]   r_res_nonce;
  logic [HASH_W-1:0]    r_res_hash;
  logic                 r_res_timeout;

  logic                 w_byte_vld;
  logic [ASM_W-1:0]     w_job;
  logic                 w_last_byte;

  assign in_ready    = (r_state == ST_LOAD);
  assign busy        = (r_state == ST_ARM) || (r_state == ST_RUN);
  assign w_byte_vld  = in_valid && in_ready;
  assign payload     = r_payload;
  assign target      = r_target;
  assign active      = r_active;
  assign res_valid   = r_res_valid;
  assign res_nonce   = r_res_nonce;
  assign res_hash    = r_res_hash;
  assign res_timeout = r_res_timeout;

  job_byte_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_byte_vld  (w_byte_vld),
    .i_byte      (in_data),
    .o_job       (w_job),
    .o_last_byte (w_last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_LOAD;
      r_wdog        <= '0;
      r_payload     <= '0;
      r_target      <= '0;
      r_active      <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_nonce   <= '0;
      r_res_hash    <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_last_byte) begin
            r_payload <= w_job[ASM_W-1:TARGET_W];
            r_target  <= w_job[TARGET_W-1:0];
            // A zero target can never be met, so reject without starting the core.
            if (w_job[TARGET_W-1:0] == '0) begin
              r_state       <= ST_DONE;
              r_res_valid   <= 1'b1;
              r_res_timeout <= 1'b1;
              r_res_nonce   <= '0;
              r_res_hash    <= '0;
            end else begin
              r_state <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          r_state  <= ST_RUN;
          r_active <= 1'b1;
        end
        ST_RUN: begin
          r_wdog <= r_wdog + 32'd1;
          if (terminado) begin
            r_state       <= ST_DONE;
            r_active      <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b0;
            r_res_nonce   <= nonce_in;
            r_res_hash    <= hash_in;
          end else if (r_wdog == MAX_CYCLES - 32'd1) begin
            r_state       <= ST_DONE;
            r_active      <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b1;
            r_res_nonce   <= '0;
            r_res_hash    <= '0;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state     <= ST_LOAD;
            r_res_valid <= 1'b0;
            r_wdog      <= '0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_job_loader.sv
// Randomized bench for job_loader: a timeline model predicts every output each cycle from job timing.
module tb_job_loader;

  localparam logic [31:0] MAXC = 32'd64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [95:0]  payload;
  logic [7:0]   target;
  logic         active;
  logic         terminado;
  logic [31:0]  nonce_in;
  logic [23:0]  hash_in;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [23:0]  res_hash;
  logic         res_timeout;
  logic         busy;

  job_loader #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .payload(payload), .target(target), .active(active), .terminado(terminado),
    .nonce_in(nonce_in), .hash_in(hash_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_hash(res_hash), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edge index of the last job byte (m_L), edge at which the result appears (m_done).
  int           m_L = -1;
  int           m_done = 0;
  int           m_k = 0;
  logic [103:0] m_job = '0;
  logic [31:0]  m_nonce = '0;
  logic [23:0]  m_hash = '0;
  logic [31:0]  cur_nonce = '0, prev_nonce = '0;
  logic [23:0]  cur_hash = '0, prev_hash = '0;
  logic         cur_to = 1'b0, prev_to = 1'b0;
  bit           chk_en = 1'b0;
  int           act_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int e;
        bit inflight;
        bit done_ph;
        e        = cyc;
        inflight = (m_L >= 0) && (e >= m_L);
        done_ph  = inflight && (e >= m_done);
        if (active === 1'b1) act_cnt++;
        check("in_ready", 128'(in_ready), 128'(!inflight));
        check("active", 128'(active), 128'(inflight && !done_ph && (e >= m_L + 1)));
        check("busy", 128'(busy), 128'(inflight && !done_ph));
        check("res_valid", 128'(res_valid), 128'(done_ph));
        check("res_nonce", 128'(res_nonce), 128'(done_ph ? cur_nonce : prev_nonce));
        check("res_hash", 128'(res_hash), 128'(done_ph ? cur_hash : prev_hash));
        check("res_timeout", 128'(res_timeout), 128'(done_ph ? cur_to : prev_to));
        if (inflight) begin
          check("payload", 128'(payload), 128'(m_job[103:8]));
          check("target", 128'(target), 128'(m_job[7:0]));
        end
      end
    end
  end

  // Core stand-in: terminado in RUN cycle m_k only; random noise whenever the job is not running.
  initial begin
    terminado = 1'b0;
    nonce_in  = '0;
    hash_in   = '0;
    forever begin
      int  e;
      bit  inrun;
      @(posedge clk);
      #2;
      e     = cyc;
      inrun = (m_L >= 0) && (e >= m_L + 1) && (e < m_done);
      if (inrun && m_k > 0 && e == m_L + m_k) begin
        terminado = 1'b1;
        nonce_in  = m_nonce;
        hash_in   = m_hash;
      end else begin
        terminado = inrun ? 1'b0 : 1'($urandom);
        nonce_in  = $urandom;
        hash_in   = 24'($urandom);
      end
    end
  end

  task automatic load_bytes(input logic [103:0] job, input bit gaps);
    for (int i = 0; i < 13; i++) begin
      int n;
      if (gaps && ($urandom % 3 == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = job[103 - 8*i -: 8];
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept: in_ready stuck at %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (i == 12) begin
        m_job = job;
        m_L   = cyc;
        if (job[7:0] == 8'h00) begin
          m_done = m_L;
          cur_to = 1'b1; cur_nonce = '0; cur_hash = '0;
        end else if (m_k == 0) begin
          m_done = m_L + 1 + int'(MAXC);
          cur_to = 1'b1; cur_nonce = '0; cur_hash = '0;
        end else begin
          m_done = m_L + 1 + m_k;
          cur_to = 1'b0; cur_nonce = m_nonce; cur_hash = m_hash;
        end
      end
    end
  endtask

  task automatic wait_result(output int lat);
    int n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_wait: res_valid=%b after 400 cycles, expected 1", res_valid);
    end
    lat = cyc - m_L;
  endtask

  task automatic ack(input int rdly, input bit hold_in);
    if (hold_in) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
    end
    repeat (rdly) @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready  = 1'b0;
    in_valid   = 1'b0;
    m_L        = -1;
    prev_nonce = cur_nonce;
    prev_hash  = cur_hash;
    prev_to    = cur_to;
  endtask

  task automatic pulse_reset(input string tag);
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check({tag, "_active"}, 128'(active), 128'(0));
    check({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_payload"}, 128'(payload), 128'(0));
    m_L = -1;
    prev_nonce = '0; prev_hash = '0; prev_to = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    int           lat;
    logic [103:0] job;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_active", 128'(active), 128'(0));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_res_timeout", 128'(res_timeout), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Nominal job, terminado in RUN cycle 50.
    m_k = 50; m_nonce = 32'h0000002A; m_hash = 24'h0B0A55; act_cnt = 0;
    load_bytes(104'h000102030405060708090A0B0C, 1'b0);
    check("t1_payload", 128'(payload), 128'(96'h000102030405060708090A0B));
    check("t1_target", 128'(target), 128'(8'h0C));
    @(negedge clk);
    check("t1_arm_active", 128'(active), 128'(0));
    @(negedge clk);
    check("t1_run_active", 128'(active), 128'(1));
    wait_result(lat);
    check("t1_latency", 128'(lat), 128'(51));
    check("t1_nonce", 128'(res_nonce), 128'(32'h2A));
    check("t1_hash", 128'(res_hash), 128'(24'h0B0A55));
    check("t1_timeout", 128'(res_timeout), 128'(0));
    check("t1_run_cycles", 128'(act_cnt), 128'(50));
    ack(0, 1'b0);

    // Same job, no terminado: watchdog expiry after exactly MAXC RUN cycles.
    m_k = 0; act_cnt = 0;
    load_bytes(104'h000102030405060708090A0B0C, 1'b0);
    wait_result(lat);
    check("t2_latency", 128'(lat), 128'(65));
    check("t2_timeout", 128'(res_timeout), 128'(1));
    check("t2_nonce", 128'(res_nonce), 128'(0));
    check("t2_active", 128'(active), 128'(0));
    check("t2_run_cycles", 128'(act_cnt), 128'(64));
    ack(3, 1'b0);

    // Zero target: rejected one cycle after the last byte, core never started.
    m_k = 5; act_cnt = 0;
    load_bytes(104'h000102030405060708090A0B00, 1'b0);
    wait_result(lat);
    check("t3_latency", 128'(lat), 128'(0));
    check("t3_timeout", 128'(res_timeout), 128'(1));
    check("t3_hash", 128'(res_hash), 128'(0));
    ack(1, 1'b0);
    check("t3_run_cycles", 128'(act_cnt), 128'(0));

    // terminado on the watchdog's final cycle wins over the timeout.
    m_k = 64; m_nonce = 32'hDEADBEEF; m_hash = 24'h123456;
    load_bytes(104'h0102030405060708090A0B0C0D, 1'b0);
    wait_result(lat);
    check("t4_latency", 128'(lat), 128'(65));
    check("t4_timeout", 128'(res_timeout), 128'(0));
    check("t4_nonce", 128'(res_nonce), 128'(32'hDEADBEEF));
    ack(0, 1'b0);

    // Result backpressure for 10 cycles with a byte waiting, then the next job loads cleanly.
    m_k = 3; m_nonce = 32'h01020304; m_hash = 24'hABCDEF;
    load_bytes(104'hF0E1D2C3B4A5968778695A4B3C, 1'b0);
    wait_result(lat);
    ack(10, 1'b1);
    m_k = 5; m_nonce = 32'h55AA55AA; m_hash = 24'h00FF00;
    load_bytes(104'h112233445566778899AABBCC7E, 1'b0);
    check("t5_payload", 128'(payload), 128'(96'h112233445566778899AABBCC));
    check("t5_target", 128'(target), 128'(8'h7E));
    wait_result(lat);
    check("t5_nonce", 128'(res_nonce), 128'(32'h55AA55AA));
    ack(0, 1'b0);

    // Reset during RUN cycle 5, then a fresh job.
    m_k = 0;
    load_bytes(104'h0A0B0C0D0E0F10111213141516, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    pulse_reset("t6_rst");
    m_k = 7; m_nonce = 32'hCAFEF00D; m_hash = 24'h654321;
    load_bytes(104'h2122232425262728292A2B2C2D, 1'b1);
    check("t6_payload", 128'(payload), 128'(96'h2122232425262728292A2B2C));
    wait_result(lat);
    check("t6_latency", 128'(lat), 128'(8));
    check("t6_hash", 128'(res_hash), 128'(24'h654321));
    ack(2, 1'b0);

    // Partial job discarded by reset.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h77;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    pulse_reset("t7_rst");
    m_k = 2; m_nonce = 32'h13579BDF; m_hash = 24'h2468AC;
    load_bytes(104'h3132333435363738393A3B3C3D, 1'b0);
    check("t7_payload", 128'(payload), 128'(96'h3132333435363738393A3B3C));
    check("t7_target", 128'(target), 128'(8'h3D));
    wait_result(lat);
    ack(0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      job = {$urandom, $urandom, $urandom, 8'($urandom)};
      if ($urandom % 5 == 0) job[7:0] = 8'h00;
      else if (job[7:0] == 8'h00) job[7:0] = 8'h01;
      m_k     = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 64));
      m_nonce = $urandom;
      m_hash  = 24'($urandom);
      load_bytes(job, 1'b1);
      wait_result(lat);
      ack(int'($urandom_range(0, 4)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
